// File: rtl/deck_pkg.sv
// Shared constants, FSM state encoding and the rejection-sampling mask helper
// for the deck shuffler and its consumers.
package deck_pkg;

    localparam int                DECK_SIZE = 52;
    localparam int                CARD_W    = 6;
    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUFFLE,
        STREAM,
        DONE
    } state_t;

    // Smallest all-ones mask covering i, i.e. 2^ceil(log2(i+1)) - 1.
    // Smearing the top set bit downwards gives it without a log2 unit.
    function automatic logic [CARD_W-1:0] mask_for(input logic [CARD_W-1:0] i);
        logic [CARD_W-1:0] m;
        m = i;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_prng.sv
// Free-running Galois LFSR. Advances every cycle out of reset; a zero seed
// would lock the register, so it is replaced by 1.
module lfsr_prng #(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = W'(16'hB400),
    parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? W'(1) : SEED;

    // Right-shifting Galois step: feed the dropped LSB back through the taps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= SEED_NZ;
        end else if (value[0]) begin
            value <= (value >> 1) ^ TAPS;
        end else begin
            value <= value >> 1;
        end
    end

endmodule

// File: rtl/deck_shuffler.sv
// Builds a 52-card deck, Fisher-Yates shuffles it with a free-running LFSR
// (rejection sampling against a power-of-two mask), then streams the cards
// over a valid/ready interface.
module deck_shuffler
    import deck_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle_en,
    input  logic              card_ready,
    output logic [CARD_W-1:0] card,
    output logic              card_valid,
    output logic              load_flag,
    output logic              busy,
    output logic              done,
    output logic [CARD_W-1:0] cards_left
);

    localparam logic [CARD_W-1:0] LAST = CARD_W'(DECK_SIZE - 1);

    state_t                           state;
    logic [LFSR_W-1:0]                lfsr;
    logic [DECK_SIZE-1:0][CARD_W-1:0] deck;
    logic [CARD_W-1:0]                idx;
    logic [CARD_W-1:0]                ptr;
    logic [CARD_W-1:0]                r;
    logic                             accept;
    logic                             xfer;
    logic                             abort;
    logic                             unused_lfsr;

    lfsr_prng #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    // Only the low bits feed the draw; the rest just keep the period long.
    assign unused_lfsr = ^lfsr[LFSR_W-1:CARD_W];

    assign r      = lfsr[CARD_W-1:0] & mask_for(idx);
    assign accept = (state == SHUFFLE) && (r <= idx);
    assign xfer   = card_valid && card_ready;
    assign abort  = !shuffle_en && (state == INIT || state == SHUFFLE || state == STREAM);

    // Deck storage needs no reset: INIT rewrites every entry before use.
    // Identity load in INIT, one swap per accepted draw (r == idx is a no-op).
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int k = 0; k < DECK_SIZE; k++) begin
                deck[k] <= CARD_W'(k);
            end
        end else if (accept) begin
            deck[idx] <= deck[r];
            deck[r]   <= deck[idx];
        end
    end

    // Control FSM with registered outputs; abort beats every other transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            ptr        <= '0;
            card       <= '0;
            card_valid <= 1'b0;
            load_flag  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cards_left <= '0;
        end else if (abort) begin
            // A card handed over on this same edge is simply gone with the deck.
            state      <= IDLE;
            card_valid <= 1'b0;
            load_flag  <= 1'b0;
            busy       <= 1'b0;
            cards_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (shuffle_en) begin
                        state <= INIT;
                        busy  <= 1'b1;
                    end
                end
                INIT: begin
                    state      <= SHUFFLE;
                    idx        <= LAST;
                    cards_left <= CARD_W'(DECK_SIZE);
                end
                SHUFFLE: begin
                    if (accept) begin
                        idx <= idx - 1'b1;
                        if (idx == CARD_W'(1)) begin
                            state      <= STREAM;
                            ptr        <= '0;
                            busy       <= 1'b0;
                            card_valid <= 1'b1;
                            load_flag  <= 1'b1;
                            // Final swap lands on this edge: pick post-swap deck[0].
                            card       <= (r == '0) ? deck[1] : deck[0];
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        cards_left <= cards_left - 1'b1;
                        if (ptr == LAST) begin
                            state      <= DONE;
                            card_valid <= 1'b0;
                            load_flag  <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            ptr  <= ptr + 1'b1;
                            card <= deck[ptr + 1'b1];
                        end
                    end
                end
                DONE: begin
                    if (!shuffle_en) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: reset, full decks, backpressure, abort,
// async reset mid-shuffle and start-time determinism. Expected decks come from
// an independent Fisher-Yates model fed by a bench-side copy of the LFSR.
module tb_deck_shuffler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       shuffle_en = 1'b0;
    logic       card_ready = 1'b0;
    logic [5:0] card;
    logic [5:0] cards_left;
    logic       card_valid;
    logic       load_flag;
    logic       busy;
    logic       done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_lfsr;
    int          exp_deck[52];
    int          exp_cycles;
    int          obs_seq[52];
    int          seq_a[52];

    deck_shuffler #(.SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst        (rst),
        .shuffle_en (shuffle_en),
        .card_ready (card_ready),
        .card       (card),
        .card_valid (card_valid),
        .load_flag  (load_flag),
        .busy       (busy),
        .done       (done),
        .cards_left (cards_left)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Bench copy of the PRNG so the model knows what the shuffler will draw.
    always @(posedge clk or negedge rst) begin
        if (!rst) ref_lfsr <= 16'hACE1;
        else      ref_lfsr <= lfsr_step(ref_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fisher-Yates with rejection, starting from the LFSR value of the first draw.
    task automatic model_deck(input logic [15:0] l0);
        logic [15:0] l;
        int i, r, m, t;
        l = l0;
        i = 51;
        for (int k = 0; k < 52; k++) exp_deck[k] = k;
        exp_cycles = 0;
        while (i >= 1 && exp_cycles < 5000) begin
            m = 0;
            while (m < i) m = m * 2 + 1;
            r = int'(l[5:0]) & m;
            exp_cycles++;
            if (r <= i) begin
                t = exp_deck[i];
                exp_deck[i] = exp_deck[r];
                exp_deck[r] = t;
                i--;
            end
            l = lfsr_step(l);
        end
    endtask

    // Raise shuffle_en now; the first draw happens two edges after IDLE->INIT.
    task automatic start_deck();
        int nbusy;
        nbusy = 0;
        model_deck(lfsr_step(lfsr_step(ref_lfsr)));
        shuffle_en = 1'b1;
        for (int c = 0; c < 3000 && !card_valid; c++) begin
            tick();
            if (busy) nbusy++;
        end
        chk("shuffle_cycles", nbusy, exp_cycles + 1);
        chk("stream_valid", 32'(card_valid), 1);
        chk("stream_load_flag", 32'(load_flag), 1);
    endtask

    task automatic stream_deck(input int stall_p, input int abort_p);
        bit seen[64];
        int distinct;
        distinct = 0;
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        card_ready = 1'b1;
        for (int p = 0; p < 52; p++) begin
            chk("card", 32'(card), exp_deck[p]);
            chk("cards_left", 32'(cards_left), 52 - p);
            chk("valid", 32'(card_valid), 1);
            obs_seq[p] = int'(card);
            if (!seen[card]) begin
                seen[card] = 1'b1;
                distinct++;
            end
            if (p == stall_p) begin
                card_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("stall_card", 32'(card), exp_deck[p]);
                    chk("stall_left", 32'(cards_left), 52 - p);
                    chk("stall_valid", 32'(card_valid), 1);
                end
                card_ready = 1'b1;
            end
            if (p == abort_p) begin
                shuffle_en = 1'b0;
                tick();
                chk("abort_valid", 32'(card_valid), 0);
                chk("abort_left", 32'(cards_left), 0);
                chk("abort_load_flag", 32'(load_flag), 0);
                chk("abort_busy", 32'(busy), 0);
                return;
            end
            tick();
        end
        chk("distinct_codes", distinct, 52);
        chk("end_done", 32'(done), 1);
        chk("end_valid", 32'(card_valid), 0);
        chk("end_left", 32'(cards_left), 0);
        chk("end_load_flag", 32'(load_flag), 0);
        tick();
        chk("done_hold", 32'(done), 1);
    endtask

    task automatic reset_and_wait(input int n);
        rst = 1'b0;
        shuffle_en = 1'b0;
        card_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (n) tick();
    endtask

    function automatic int differs();
        for (int k = 0; k < 52; k++) begin
            if (obs_seq[k] != seq_a[k]) return 1;
        end
        return 0;
    endfunction

    initial begin
        // Reset held with shuffle_en high: everything stays cleared.
        rst = 1'b0;
        shuffle_en = 1'b1;
        card_ready = 1'b0;
        repeat (3) tick();
        chk("reset_card", 32'(card), 0);
        chk("reset_valid", 32'(card_valid), 0);
        chk("reset_load_flag", 32'(load_flag), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_left", 32'(cards_left), 0);

        // Release: INIT then SHUFFLE, busy high on the second edge.
        rst = 1'b1;
        tick();
        tick();
        chk("busy_2nd_edge", 32'(busy), 1);
        chk("shuffle_left", 32'(cards_left), 52);

        // Asynchronous reset between edges, mid-SHUFFLE.
        #3 rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_left", 32'(cards_left), 0);
        chk("async_valid", 32'(card_valid), 0);

        // Deck A: full run with card_ready held high.
        reset_and_wait(3);
        start_deck();
        stream_deck(-1, -1);
        seq_a = obs_seq;

        // DONE clears when shuffle_en falls; deck B must differ.
        shuffle_en = 1'b0;
        tick();
        chk("done_clear", 32'(done), 0);
        start_deck();
        stream_deck(-1, -1);
        chk("deck_b_differs", differs(), 1);

        // Backpressure at cards_left == 30.
        shuffle_en = 1'b0;
        tick();
        start_deck();
        stream_deck(22, -1);

        // Abort at cards_left == 20 with a transfer on the same edge, then a fresh deck.
        shuffle_en = 1'b0;
        tick();
        start_deck();
        stream_deck(-1, 32);
        tick();
        start_deck();
        stream_deck(-1, -1);

        // Same start cycle after reset repeats deck A; one cycle later does not.
        reset_and_wait(3);
        start_deck();
        stream_deck(-1, -1);
        chk("same_start_same_deck", differs(), 0);
        reset_and_wait(4);
        start_deck();
        stream_deck(-1, -1);
        chk("later_start_differs", differs(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
